// File: rtl/wb_ram_ctrl.sv
// wb_ram_ctrl: Wishbone B4 classic slave in front of an inferred single-port
// synchronous RAM, used as the core's data memory.
//
// Honours byte selects, inserts WAIT_ST wait states before the acknowledge,
// and answers out-of-range word addresses with err_o instead of ack_o.
// Optional feature macro: WBRAM_BURST_EN. When it is defined, linear
// incrementing bursts (cti_i=3'b010, bte_i=2'b00) run at one beat per cycle
// after the first beat. When it is undefined, cti_i and bte_i are ignored.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge) and asynchronous active-low reset
//   cyc_i, stb_i, we_i  bus cycle, strobe and write enable
//   sel_i [DATA_W/8]    byte-lane selects
//   adr_i [ADDR_W]      byte address
//   dat_i [DATA_W]      write data
//   cti_i, bte_i        burst cycle type and burst type (burst build only)
//   dat_o [DATA_W]      read data; holds until the next read acknowledge
//   ack_o, err_o        registered terminations; never high together
module wb_ram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int WAIT_ST   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic [2:0]          cti_i,
  input  logic [1:0]          bte_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
`ifdef WBRAM_BURST_EN
    , BURST
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  // Latched request; data-path registers carry no reset.
  logic [WA_W-1:0]     addr_q, addr_d;
  logic                we_q, we_d;
  logic [NB-1:0]       sel_q, sel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wdat;
  logic [NB-1:0]       mem_sel;
  logic [DATA_W-1:0]   rd_word;

  // Byte-offset bits and, in the classic build, the burst qualifiers are
  // deliberately not decoded.
  logic unused_ok;
  assign unused_ok = ^{cti_i, bte_i, adr_i};

`ifdef WBRAM_BURST_EN
  logic                burst_q, burst_d;
  logic [WA_W-1:0]     addr_inc;
  logic [DATA_W-1:0]   rd_next;
  assign addr_inc = addr_q + 1'b1;
  // Next beat's word is read ahead so consecutive read beats have no bubble.
  assign rd_next  = mem[addr_inc[IDX_W-1:0]];
`endif

  // Every upper word-address bit is compared, so a wide address never
  // aliases back into the RAM.
  function automatic logic out_of_range(input logic [WA_W-1:0] wa);
    return (wa >> IDX_W) != '0;
  endfunction

  assign rd_word = mem[addr_q[IDX_W-1:0]];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    mem_we   = 1'b0;
    mem_idx  = addr_q[IDX_W-1:0];
    mem_wdat = wdat_q;
    mem_sel  = sel_q;
`ifdef WBRAM_BURST_EN
    burst_d  = burst_q;
`endif
    case (state_q)
      IDLE: begin
        // A request still present during the termination cycle belongs to
        // the transfer just answered, hence the one-cycle idle gap.
        if (cyc_i && stb_i && !ack_q && !err_q) begin
          addr_d  = adr_i[ADDR_W-1:OFF_W];
          we_d    = we_i;
          sel_d   = sel_i;
          wdat_d  = dat_i;
          cnt_d   = 3'(WAIT_ST);
          state_d = (WAIT_ST > 0) ? WAIT : RESP;
`ifdef WBRAM_BURST_EN
          burst_d = (cti_i == 3'b010) && (bte_i == 2'b00);
`endif
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (cyc_i) begin
          if (out_of_range(addr_q)) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (we_q) mem_we = 1'b1;
            else      dat_d  = rd_word;
`ifdef WBRAM_BURST_EN
            if (burst_q) state_d = BURST;
`endif
          end
        end
      end
`ifdef WBRAM_BURST_EN
      // ack_q is high here: the master is presenting the beat being acked at
      // addr_q, and this edge decides whether the following beat is acked.
      BURST: begin
        state_d = IDLE;
        if (cyc_i && stb_i) begin
          if (we_q) begin
            mem_we   = 1'b1;
            mem_wdat = dat_i;
            mem_sel  = sel_i;
          end
          if (cti_i != 3'b111) begin
            addr_d = addr_inc;
            if (out_of_range(addr_inc)) begin
              err_d = 1'b1;
            end else begin
              ack_d   = 1'b1;
              state_d = BURST;
              if (!we_q) dat_d = rd_next;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
`ifdef WBRAM_BURST_EN
      burst_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
`ifdef WBRAM_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    we_q   <= we_d;
    sel_q  <= sel_d;
    wdat_q <= wdat_d;
  end

  // mem_we derives from state_q, which reset forces to IDLE, so an unacked
  // write is never committed once reset has been asserted.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_sel[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = dat_q;
endmodule
